// File: rtl/pin_scheduler.sv
// Timed bus master for the pin-controller register bus: replays host-loaded
// (timestamp, address, data) entries against a free-running timebase and
// arbitrates untimed direct host writes onto the same one-cycle write bus.
module pin_scheduler #(
  parameter int unsigned       DEPTH     = 16,
  parameter int unsigned       ADDR_W    = 21,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       TS_W      = 32,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(21'h1FFFFF),
  parameter int unsigned       LATE_TOL  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [TS_W-1:0]          cmd_time,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic                     dir_valid,
  output logic                     dir_ready,
  input  logic [ADDR_W-1:0]        dir_addr,
  input  logic [DATA_W-1:0]        dir_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clear,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_data,
  output logic                     bus_we,
  output logic                     running,
  output logic [TS_W-1:0]          time_now,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              late_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

  state_t             state, state_next;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  entry_t             head;
  logic               push_c, pop_c;
  logic [TS_W-1:0]    lag;

  assign head      = mem[rd_ptr];
  assign running   = (state == ST_RUNNING);
  assign cmd_ready = (fifo_count < CNT_W'(DEPTH));
  assign push_c    = cmd_valid && cmd_ready && !clear;
  assign pop_c     = running && (fifo_count != '0) && (time_now >= head.ts);
  assign dir_ready = !pop_c;
  assign lag       = time_now - head.ts;

  // Run-control state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_STOPPED;
    else       state <= state_next;
  end

  // Run-control next state: stop/clear dominate start
  always_comb begin
    state_next = state;
    case (state)
      ST_STOPPED: if (start && !stop && !clear) state_next = ST_RUNNING;
      ST_RUNNING: if (stop || clear)            state_next = ST_STOPPED;
      default:                                  state_next = ST_STOPPED;
    endcase
  end

  // Timebase advances only while running; wraps naturally
  always_ff @(posedge clk) begin
    if (reset || clear) time_now <= '0;
    else if (running)   time_now <= time_now + TS_W'(1);
  end

  // Schedule FIFO storage (pointers reset separately, contents need none)
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= '{ts: cmd_time, addr: cmd_addr, data: cmd_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Late-issue counter, saturating
  always_ff @(posedge clk) begin
    if (reset || clear) late_cnt <= '0;
    else if (pop_c && (lag > TS_W'(LATE_TOL)) && (late_cnt != 16'hFFFF))
      late_cnt <= late_cnt + 16'd1;
  end

  // Bus driver: scheduled pop wins, then direct write, else park idle
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_addr <= IDLE_ADDR;
      bus_data <= '0;
      bus_we   <= 1'b0;
    end else if (pop_c && !clear) begin
      bus_addr <= head.addr;
      bus_data <= head.data;
      bus_we   <= 1'b1;
    end else if (dir_valid && dir_ready) begin
      bus_addr <= dir_addr;
      bus_data <= dir_data;
      bus_we   <= 1'b1;
    end else begin
      bus_addr <= IDLE_ADDR;
      bus_data <= '0;
      bus_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pin_scheduler.sv
// Directed bench for pin_scheduler: timed issue, arbitration, full FIFO,
// stop/resume, late detection and reset during a pop.
module tb_pin_scheduler;

  localparam logic [20:0] IDLE = 21'h1FFFFF;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, dir_valid, start, stop, clear;
  logic        cmd_ready, dir_ready, bus_we, running;
  logic [31:0] cmd_time, time_now;
  logic [20:0] cmd_addr, dir_addr, bus_addr;
  logic [15:0] cmd_data, dir_data, bus_data, late_cnt;
  logic [4:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;

  pin_scheduler dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_time(cmd_time),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .dir_valid(dir_valid), .dir_ready(dir_ready), .dir_addr(dir_addr),
    .dir_data(dir_data),
    .start(start), .stop(stop), .clear(clear),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
    .running(running), .time_now(time_now), .fifo_count(fifo_count),
    .late_cnt(late_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs and samples are taken 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] t, input logic [20:0] a, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_time = t; cmd_addr = a; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic check_bus(input string tag, input logic we, input logic [20:0] a, input logic [15:0] d);
    check({tag, "_we"},   64'(bus_we),   64'(we));
    check({tag, "_addr"}, 64'(bus_addr), 64'(a));
    check({tag, "_data"}, 64'(bus_data), 64'(d));
  endtask

  // Bounded runtime
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        any_we;
    logic        seen;
    logic [20:0] ea;
    logic [15:0] ed;

    reset = 1'b1; cmd_valid = 1'b0; dir_valid = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    cmd_time = '0; cmd_addr = '0; cmd_data = '0; dir_addr = '0; dir_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check_bus("rst", 1'b0, IDLE, 16'h0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_time",    64'(time_now), 64'd0);
    check("rst_count",   64'(fifo_count), 64'd0);
    check("rst_ready",   64'(cmd_ready), 64'd1);
    check("rst_late",    64'(late_cnt), 64'd0);

    // Basic timed issue: writes at S+6, S+7, S+11
    push(32'd5, 21'd4, 16'h0010);
    push(32'd5, 21'd8, 16'h0020);
    push(32'd10, 21'd0, 16'h0001);
    check("t1_count", 64'(fifo_count), 64'd3);
    pulse_start();
    check("t1_running", 64'(running), 64'd1);
    check("t1_time0",   64'(time_now), 64'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      ea = (k == 6) ? 21'd4 : (k == 7) ? 21'd8 : (k == 11) ? 21'd0 : IDLE;
      ed = (k == 6) ? 16'h0010 : (k == 7) ? 16'h0020 : (k == 11) ? 16'h0001 : 16'h0;
      check_bus($sformatf("t1_k%0d", k), (k == 6 || k == 7 || k == 11), ea, ed);
    end
    check("t1_late",  64'(late_cnt), 64'd0);
    check("t1_empty", 64'(fifo_count), 64'd0);

    // Start together with clear: clear wins
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    check("clr_running", 64'(running), 64'd0);
    check("clr_time",    64'(time_now), 64'd0);

    // Arbitration: direct write held across the pop cycle
    push(32'd3, 21'd4, 16'h0033);
    pulse_start();
    tick(); tick(); tick();
    dir_valid = 1'b1; dir_addr = 21'd8; dir_data = 16'h00AA;
    check("arb_time", 64'(time_now), 64'd3);
    check("arb_ready_pop", 64'(dir_ready), 64'd0);
    tick();
    check_bus("arb_sched", 1'b1, 21'd4, 16'h0033);
    check("arb_ready_after", 64'(dir_ready), 64'd1);
    tick();
    dir_valid = 1'b0;
    check_bus("arb_dir", 1'b1, 21'd8, 16'h00AA);
    tick();
    check_bus("arb_idle", 1'b0, IDLE, 16'h0);

    // Full FIFO then 16 back-to-back issues
    pulse_clear();
    for (int i = 0; i < 16; i++) push(32'd1000, 21'(i), 16'(i));
    check("full_count", 64'(fifo_count), 64'd16);
    check("full_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_time = 32'd0; cmd_addr = 21'd9; cmd_data = 16'h9;
    tick();
    cmd_valid = 1'b0;
    check("full_reject", 64'(fifo_count), 64'd16);
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 1100 && !seen; n++) begin
      if (bus_we) seen = 1'b1;
      else tick();
    end
    check("full_seen", 64'(seen), 64'd1);
    check("full_first_time", 64'(time_now), 64'd1001);
    for (int j = 0; j < 16; j++) begin
      check_bus($sformatf("full_j%0d", j), 1'b1, 21'(j), 16'(j));
      tick();
    end
    check_bus("full_done", 1'b0, IDLE, 16'h0);
    check("full_drained", 64'(fifo_count), 64'd0);
    check("full_ready2",  64'(cmd_ready), 64'd1);
    check("full_late",    64'(late_cnt), 64'd11);

    // Stop at time 7, hold, resume
    pulse_clear();
    push(32'd8, 21'd12, 16'h0077);
    pulse_start();
    for (int k = 0; k < 6; k++) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_running", 64'(running), 64'd0);
    any_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      any_we = any_we | bus_we;
    end
    check("stop_time", 64'(time_now), 64'd7);
    check("stop_no_we", 64'(any_we), 64'd0);
    check("stop_count", 64'(fifo_count), 64'd1);
    pulse_start();
    check("resume_time", 64'(time_now), 64'd7);
    tick();
    check("resume_time8", 64'(time_now), 64'd8);
    tick();
    check_bus("resume_issue", 1'b1, 21'd12, 16'h0077);
    check("resume_late", 64'(late_cnt), 64'd0);

    // Late entry pushed after its time
    pulse_clear();
    pulse_start();
    for (int k = 0; k < 20; k++) tick();
    check("late_time", 64'(time_now), 64'd20);
    push(32'd2, 21'd4, 16'h0001);
    check("late_pending", 64'(fifo_count), 64'd1);
    tick();
    check_bus("late_issue", 1'b1, 21'd4, 16'h0001);
    check("late_cnt", 64'(late_cnt), 64'd1);

    // Reset in the pop cycle
    pulse_clear();
    push(32'd3, 21'd4, 16'h0005);
    pulse_start();
    tick(); tick(); tick();
    check("rstpop_ready", 64'(dir_ready), 64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    check_bus("rstpop", 1'b0, IDLE, 16'h0);
    check("rstpop_count",   64'(fifo_count), 64'd0);
    check("rstpop_running", 64'(running), 64'd0);
    check("rstpop_time",    64'(time_now), 64'd0);
    tick();
    check("rstpop_we_later", 64'(bus_we), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
